rtc_init_sequencer: RTL
=======================

Name: rtc_init_sequencer

Overview:
Table-driven register-initialisation sequencer for the RTC bus controller. On start it walks a parametrised list of (address, data) steps. Each step is issued as a write transaction over a req/done handshake. An optional read-back verify with bounded retry can follow each write. A per-transaction timeout guards every transaction. Sits between the top-level control FSM and the RTC parallel-bus driver, and reports busy, done, error and the current step.

Parameters:
ADDR_W, 8, bus address width
DATA_W, 8, bus data width
NUM_STEPS, 5, number of table entries (1..16)
VERIFY, 0, 1 = read back and compare after every write
MAX_RETRY, 2, extra attempts per step on verify mismatch (0..7)
TIMEOUT, 255, cycles to wait for bus_done before declaring error (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  begin sequence; sampled only in IDLE/DONE/ERR
abort  in  1  return to IDLE at next edge from any state
bus_done  in  1  one-cycle completion strobe from bus driver
bus_rdata  in  DATA_W  read data, valid with bus_done on reads
bus_req  out  1  transaction request, held until bus_done
bus_wr  out  1  1 = write, 0 = read; valid while bus_req
bus_addr  out  ADDR_W  transaction address
bus_wdata  out  DATA_W  write data
busy  out  1  high from start accept until DONE/ERR/IDLE
done  out  1  one-cycle pulse after last step succeeds
error  out  1  level, high in ERR until next start or reset
step_idx  out  4  index of current/failing step

Behaviour:
- Reset: all outputs 0, state IDLE, step and retry counters 0.
- All outputs are registered.
- States: IDLE, ISSUE_WR, WAIT_WR, GAP, ISSUE_RD, WAIT_RD, NEXT, DONE, ERR.
- IDLE/DONE/ERR + start: step_idx<=0, retry<=0, error<=0, busy<=1, go to ISSUE_WR.
- ISSUE_WR: load bus_addr/bus_wdata from rom[step_idx]; set bus_wr=1 and bus_req=1 on the same edge; go to WAIT_WR.
- WAIT_WR:
  - bus_addr, bus_wdata, bus_wr and bus_req are held stable.
  - On bus_done: bus_req<=0; go to GAP if VERIFY, else NEXT.
  - Timeout counter increments each cycle. If it reaches TIMEOUT with no bus_done, go to ERR.
- GAP: bus_req stays low for exactly one cycle; then ISSUE_RD.
- Between any two requests bus_req is low for at least one cycle.
- ISSUE_RD: bus_wr=0, bus_req=1, same address; go to WAIT_RD.
- WAIT_RD: on bus_done compare bus_rdata to rom data.
  - Match: go to NEXT.
  - Mismatch and retry<MAX_RETRY: retry++, go to ISSUE_WR after one idle cycle.
  - Mismatch and retry==MAX_RETRY: go to ERR.
  - Timeout applies as in WAIT_WR.
- NEXT: retry<=0.
  - If step_idx==NUM_STEPS-1, go to DONE.
  - Else step_idx++ and go to ISSUE_WR.
- DONE: done=1 for exactly one cycle, busy<=0; then stays in DONE (done low) until start.
- ERR: error=1, busy=0, bus_req=0, step_idx frozen at the failing step.
- Timeout counter clears on every ISSUE_* entry.
- bus_done outside WAIT_* is ignored.
- abort, or reset mid-transaction: bus_req drops at the next edge, go to IDLE, no done/error.
  - reset has priority over abort; abort has priority over start.
- start while busy is ignored.
- Latency, VERIFY=0, bus_done returned one cycle after req: 3 cycles per step plus 1 to DONE.

Decomposition:
- Shared package rtc_pkg holds:
  - state encoding constants;
  - RTC register address constants: CTRL=8'h00, MASK=8'h01, STATUS=8'h02, HOUR=8'h23;
  - default init data constants.
- Sub-module rtc_init_rom: combinational step->(addr,data) lookup.
- Default rom contents, in step order:
  - 0: 02<-10
  - 1: 02<-00
  - 2: 01<-44
  - 3: 00<-08
  - 4: 23<-0C
- Steps beyond the table return addr 0, data 0.

Test Plan:
- VERIFY=0, bus model acks 1 cycle after req, pulse start -> 5 writes in order 02/10, 02/00, 01/44, 00/08, 23/0C; done pulses once at cycle 16; error=0.
- VERIFY=1, model returns written data -> each write followed by a read of the same address; bus_req low exactly 1 cycle between each write and its read; done asserts.
- VERIFY=1, MAX_RETRY=2, step 2 reads 00 every time -> 3 writes of 01/44, then error=1, step_idx=2, busy=0, no done.
- Bus model never acks step 3, TIMEOUT=255 -> error asserts 255 cycles after that bus_req rises; bus_req then 0.
- abort during WAIT_WR of step 1 -> bus_req 0 next cycle, IDLE, busy=0; a following start restarts at step 0 (addr 02, data 10).
- start pulsed while busy, and bus_done pulsed in IDLE -> no effect on sequence, step_idx or outputs.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC initialisation path: sequencer state encoding,
// RTC register addresses and the default power-up register values.
package rtc_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_ISSUE_WR = 4'd1,
      ST_WAIT_WR  = 4'd2,
      ST_GAP      = 4'd3,
      ST_ISSUE_RD = 4'd4,
      ST_WAIT_RD  = 4'd5,
      ST_NEXT     = 4'd6,
      ST_DONE     = 4'd7,
      ST_ERR      = 4'd8
   } state_t;

   localparam logic [7:0] RTC_CTRL   = 8'h00;
   localparam logic [7:0] RTC_MASK   = 8'h01;
   localparam logic [7:0] RTC_STATUS = 8'h02;
   localparam logic [7:0] RTC_HOUR   = 8'h23;

   localparam logic [7:0] INIT_STATUS_RST = 8'h10;
   localparam logic [7:0] INIT_STATUS_CLR = 8'h00;
   localparam logic [7:0] INIT_MASK       = 8'h44;
   localparam logic [7:0] INIT_CTRL       = 8'h08;
   localparam logic [7:0] INIT_HOUR       = 8'h0C;

endpackage

// File: rtl/rtc_init_rom.sv
// Combinational step -> (address, data) lookup for the RTC init table.
// Steps past the end of the table read back as address 0 / data 0.
module rtc_init_rom
   import rtc_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic [3:0]        step,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   // table lookup
   always_comb begin
      addr = '0;
      data = '0;
      case (step)
         4'd0: begin
            addr = ADDR_W'(RTC_STATUS);
            data = DATA_W'(INIT_STATUS_RST);
         end
         4'd1: begin
            addr = ADDR_W'(RTC_STATUS);
            data = DATA_W'(INIT_STATUS_CLR);
         end
         4'd2: begin
            addr = ADDR_W'(RTC_MASK);
            data = DATA_W'(INIT_MASK);
         end
         4'd3: begin
            addr = ADDR_W'(RTC_CTRL);
            data = DATA_W'(INIT_CTRL);
         end
         4'd4: begin
            addr = ADDR_W'(RTC_HOUR);
            data = DATA_W'(INIT_HOUR);
         end
         default: begin
            addr = '0;
            data = '0;
         end
      endcase
   end

endmodule

// File: rtl/rtc_init_sequencer.sv
// Table-driven RTC register initialisation: walks the init ROM issuing bus
// writes, optionally verifying each by read-back with bounded retry.
module rtc_init_sequencer
   import rtc_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int NUM_STEPS = 5,
   parameter int VERIFY    = 0,
   parameter int MAX_RETRY = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              bus_done,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [3:0]        step_idx
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_t            state;
   state_t            state_nx;
   logic [3:0]        step_nx;
   logic [2:0]        retry;
   logic [2:0]        retry_nx;
   logic [TMO_W-1:0]  tmo;
   logic [TMO_W-1:0]  tmo_nx;
   logic              tmo_hit;
   logic              req_nx;
   logic              wr_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic [DATA_W-1:0] wdata_nx;
   logic              busy_nx;
   logic              done_nx;
   logic              error_nx;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;

   rtc_init_rom #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_rom (
      .step (step_idx),
      .addr (rom_addr),
      .data (rom_data)
   );

   assign tmo_hit = (tmo == TMO_W'(TIMEOUT - 1));

   // next-state and next-output decode
   always_comb begin
      state_nx = state;
      step_nx  = step_idx;
      retry_nx = retry;
      tmo_nx   = tmo;
      req_nx   = bus_req;
      wr_nx    = bus_wr;
      addr_nx  = bus_addr;
      wdata_nx = bus_wdata;
      busy_nx  = busy;
      done_nx  = 1'b0;
      error_nx = error;
      if (abort) begin
         state_nx = ST_IDLE;
         req_nx   = 1'b0;
         busy_nx  = 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  step_nx  = 4'd0;
                  retry_nx = 3'd0;
                  error_nx = 1'b0;
                  busy_nx  = 1'b1;
                  state_nx = ST_ISSUE_WR;
               end else begin
                  state_nx = state;
               end
            end
            ST_ISSUE_WR: begin
               addr_nx  = rom_addr;
               wdata_nx = rom_data;
               wr_nx    = 1'b1;
               req_nx   = 1'b1;
               tmo_nx   = '0;
               state_nx = ST_WAIT_WR;
            end
            ST_WAIT_WR: begin
               // ISSUE_RD is the single low cycle between a write and its read-back
               if (bus_done) begin
                  req_nx   = 1'b0;
                  state_nx = (VERIFY != 0) ? ST_ISSUE_RD : ST_NEXT;
               end else if (tmo_hit) begin
                  req_nx   = 1'b0;
                  busy_nx  = 1'b0;
                  error_nx = 1'b1;
                  state_nx = ST_ERR;
               end else begin
                  tmo_nx = tmo + TMO_W'(1);
               end
            end
            ST_GAP: begin
               state_nx = ST_ISSUE_WR;
            end
            ST_ISSUE_RD: begin
               wr_nx    = 1'b0;
               req_nx   = 1'b1;
               tmo_nx   = '0;
               state_nx = ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
               // a failed verify idles one extra cycle in GAP before rewriting
               if (bus_done) begin
                  req_nx = 1'b0;
                  if (bus_rdata == rom_data) begin
                     state_nx = ST_NEXT;
                  end else if (retry < 3'(MAX_RETRY)) begin
                     retry_nx = retry + 3'd1;
                     state_nx = ST_GAP;
                  end else begin
                     busy_nx  = 1'b0;
                     error_nx = 1'b1;
                     state_nx = ST_ERR;
                  end
               end else if (tmo_hit) begin
                  req_nx   = 1'b0;
                  busy_nx  = 1'b0;
                  error_nx = 1'b1;
                  state_nx = ST_ERR;
               end else begin
                  tmo_nx = tmo + TMO_W'(1);
               end
            end
            ST_NEXT: begin
               retry_nx = 3'd0;
               if (step_idx == 4'(NUM_STEPS - 1)) begin
                  done_nx  = 1'b1;
                  busy_nx  = 1'b0;
                  state_nx = ST_DONE;
               end else begin
                  step_nx  = step_idx + 4'd1;
                  state_nx = ST_ISSUE_WR;
               end
            end
            default: begin
               req_nx   = 1'b0;
               busy_nx  = 1'b0;
               state_nx = ST_IDLE;
            end
         endcase
      end
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         step_idx  <= 4'd0;
         retry     <= 3'd0;
         tmo       <= '0;
         bus_req   <= 1'b0;
         bus_wr    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_nx;
         step_idx  <= step_nx;
         retry     <= retry_nx;
         tmo       <= tmo_nx;
         bus_req   <= req_nx;
         bus_wr    <= wr_nx;
         bus_addr  <= addr_nx;
         bus_wdata <= wdata_nx;
         busy      <= busy_nx;
         done      <= done_nx;
         error     <= error_nx;
      end
   end

endmodule
